// File: rtl/moore_seq_pkg.sv
// Shared definitions for the Moore FSM sequencing controller.
//   ctrl_state_t   : controller state encoding
//   MAX_STEPS      : most steps a single run can execute
//   NUM_FSM_STATES : legal states of the external Moore FSM (0..NUM_FSM_STATES-1)
//   SYM_W          : width of one input symbol
//   clamp_steps()  : limits a requested step count to MAX_STEPS
//   sym_sel()      : picks symbol i out of the packed symbol word
package moore_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STEP   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } ctrl_state_t;

    localparam int MAX_STEPS      = 8;
    localparam int NUM_FSM_STATES = 5;
    localparam int SYM_W          = 2;

    function automatic logic [3:0] clamp_steps(input logic [3:0] n);
        return (n > 4'(MAX_STEPS)) ? 4'(MAX_STEPS) : n;
    endfunction

    // Symbol i sits at bits [2i+1:2i]; the concatenation is i*SYM_W for SYM_W=2.
    function automatic logic [SYM_W-1:0] sym_sel(input logic [15:0] d, input logic [2:0] i);
        return d[{i, 1'b0} +: SYM_W];
    endfunction

endpackage

// File: rtl/moore_seq_ctrl.sv
// Sequencing controller that drives an external 5-state Moore FSM through a
// run: load a start state, then apply up to eight 2-bit symbols one at a time,
// capturing the FSM output after each step.
//
// Ports
//   clk, reset                : clock (rising edge), async active-high reset
//   start, abort              : run request (IDLE only) / cancel run
//   start_state, num_steps    : FSM start state, steps to run (clamped to 8)
//   sym_data                  : eight packed 2-bit symbols
//   busy, done, err           : status; done is a one-cycle pulse, err valid with done
//   out_bits, final_state     : captured FSM outputs per step, FSM state at completion
//   fsm_load, fsm_state_in    : FSM load strobe and the state it loads
//   fsm_step, fsm_sw          : FSM advance strobe and the symbol it consumes
//   fsm_state, fsm_out        : FSM current state and registered output
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | fsm_load high, FSM takes fsm_state_in
// STEP   | fsm_step high, FSM consumes fsm_sw
// SAMPLE | capture fsm_out, check FSM state legality, pick next step
// DONE   | done pulse, snapshot fsm_state into final_state
module moore_seq_ctrl
    import moore_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [2:0]  start_state,
    input  logic [3:0]  num_steps,
    input  logic [15:0] sym_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  out_bits,
    output logic [2:0]  final_state,
    output logic        fsm_load,
    output logic [2:0]  fsm_state_in,
    output logic [1:0]  fsm_sw,
    output logic        fsm_step,
    input  logic [2:0]  fsm_state,
    input  logic        fsm_out
);

    ctrl_state_t state;
    logic [3:0]  idx;
    logic [3:0]  steps_q;
    logic [15:0] sym_q;

    // Every output is a register updated together with the state transition,
    // so each strobe is high exactly for the cycle its state occupies.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            idx          <= '0;
            steps_q      <= '0;
            sym_q        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            out_bits     <= '0;
            final_state  <= '0;
            fsm_load     <= 1'b0;
            fsm_state_in <= '0;
            fsm_sw       <= '0;
            fsm_step     <= 1'b0;
        end else if (state == ST_IDLE) begin
            // abort wins over a simultaneous start
            if (start && !abort) begin
                fsm_state_in <= start_state;
                steps_q      <= clamp_steps(num_steps);
                sym_q        <= sym_data;
                out_bits     <= '0;
                err          <= 1'b0;
                idx          <= '0;
                fsm_load     <= 1'b1;
                busy         <= 1'b1;
                state        <= ST_LOAD;
            end
        end else if (abort) begin
            // results of earlier runs and partial captures are left untouched
            fsm_load <= 1'b0;
            fsm_step <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            state    <= ST_IDLE;
        end else begin
            case (state)
                ST_LOAD: begin
                    fsm_load <= 1'b0;
                    if (steps_q == 4'd0) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        fsm_sw   <= sym_sel(sym_q, 3'd0);
                        fsm_step <= 1'b1;
                        state    <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    fsm_step <= 1'b0;
                    state    <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    out_bits[idx[2:0]] <= fsm_out;
                    idx                <= idx + 4'd1;
                    if (fsm_state >= 3'(NUM_FSM_STATES)) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if ((idx + 4'd1) == steps_q) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        // idx+1 < steps_q <= 8, so the 3-bit index cannot wrap here
                        fsm_sw   <= sym_sel(sym_q, idx[2:0] + 3'd1);
                        fsm_step <= 1'b1;
                        state    <= ST_STEP;
                    end
                end
                ST_DONE: begin
                    // start is not looked at here; only IDLE accepts a run
                    final_state <= fsm_state;
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    fsm_load <= 1'b0;
                    fsm_step <= 1'b0;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_moore_seq_ctrl.sv
// Directed bench for moore_seq_ctrl. A small Moore FSM lives beside the DUT:
//   next  = (state - sw) mod 5 for legal states, illegal states (5..7) hold
//   out   = 1 in states 2 and 4, else 0 (registered with the state)
// so sym 2,1,0 from state 0 walks 0->3->2->2.
// Cycle k of a run is the cycle after edge E(k-1), E0 being the start edge.
module tb_moore_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [2:0]  start_state;
    logic [3:0]  num_steps;
    logic [15:0] sym_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  out_bits;
    logic [2:0]  final_state;
    logic        fsm_load;
    logic [2:0]  fsm_state_in;
    logic [1:0]  fsm_sw;
    logic        fsm_step;
    logic [2:0]  fsm_state;
    logic        fsm_out;

    int checks = 0;
    int errors = 0;

    int          r_done_cyc;
    int          r_steps;
    int          r_loads;
    int          r_overlap;
    int          r_busy_gap;
    logic        r_err_at_done;
    logic [15:0] r_sw_log;

    always #5 clk = ~clk;

    moore_seq_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .start_state  (start_state),
        .num_steps    (num_steps),
        .sym_data     (sym_data),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .out_bits     (out_bits),
        .final_state  (final_state),
        .fsm_load     (fsm_load),
        .fsm_state_in (fsm_state_in),
        .fsm_sw       (fsm_sw),
        .fsm_step     (fsm_step),
        .fsm_state    (fsm_state),
        .fsm_out      (fsm_out)
    );

    function automatic logic f_out(input logic [2:0] s);
        return (s == 3'd2) || (s == 3'd4);
    endfunction

    function automatic logic [2:0] f_next(input logic [2:0] s, input logic [1:0] sw);
        if (s > 3'd4) return s;
        return 3'((int'(s) + 5 - int'(sw)) % 5);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_state <= 3'd0;
            fsm_out   <= 1'b0;
        end else if (fsm_load) begin
            fsm_state <= fsm_state_in;
            fsm_out   <= f_out(fsm_state_in);
        end else if (fsm_step) begin
            fsm_state <= f_next(fsm_state, fsm_sw);
            fsm_out   <= f_out(f_next(fsm_state, fsm_sw));
        end
    end

    // Starts a run and records what happens until done (budget 40 cycles),
    // then waits one more cycle so final_state is settled.
    task automatic do_run(input logic [2:0] ss, input logic [3:0] ns,
                          input logic [15:0] sd, input bit hold);
        @(negedge clk);
        start_state = ss;
        num_steps   = ns;
        sym_data    = sd;
        start       = 1'b1;
        @(posedge clk);
        r_done_cyc    = -1;
        r_steps       = 0;
        r_loads       = 0;
        r_overlap     = 0;
        r_busy_gap    = 0;
        r_err_at_done = 1'b0;
        r_sw_log      = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (fsm_step) begin
                r_steps++;
                r_sw_log = {r_sw_log[13:0], fsm_sw};
            end
            if (fsm_load) r_loads++;
            if (fsm_step && fsm_load) r_overlap++;
            if (!busy) r_busy_gap++;
            if (done) begin
                r_done_cyc    = k;
                r_err_at_done = err;
                break;
            end
        end
        if (r_done_cyc > 0) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy, done, err, out_bits, final_state, fsm_load, fsm_state_in, fsm_sw, fsm_step} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {busy, done, err, out_bits, final_state, fsm_load, fsm_state_in, fsm_sw, fsm_step});
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        do_run(3'd0, 4'd3, 16'h0006, 1'b0);
        checks++;
        if (r_done_cyc !== 8) begin errors++; $display("FAIL basic_done_cycle got %0d want 8", r_done_cyc); end
        checks++;
        if (out_bits !== 8'h06) begin errors++; $display("FAIL basic_out_bits got %h want 06", out_bits); end
        checks++;
        if (final_state !== 3'd2) begin errors++; $display("FAIL basic_final_state got %0d want 2", final_state); end
        checks++;
        if (r_err_at_done !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", r_err_at_done); end
        checks++;
        if (r_steps !== 3 || r_loads !== 1 || r_overlap !== 0) begin
            errors++;
            $display("FAIL basic_pulses got steps=%0d loads=%0d overlap=%0d want 3 1 0", r_steps, r_loads, r_overlap);
        end
        checks++;
        if (r_sw_log !== 16'h0024) begin errors++; $display("FAIL basic_sw_seq got %h want 0024", r_sw_log); end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || r_busy_gap !== 0) begin
            errors++;
            $display("FAIL basic_after_done got done=%b busy=%b gaps=%0d want 0 0 0", done, busy, r_busy_gap);
        end
        checks++;
        if (fsm_sw !== 2'd0) begin errors++; $display("FAIL basic_sw_hold got %0d want 0", fsm_sw); end
    endtask

    task automatic test_clamp();
        do_run(3'd0, 4'd12, 16'hE4E4, 1'b0);
        checks++;
        if (r_done_cyc !== 18) begin errors++; $display("FAIL clamp_done_cycle got %0d want 18", r_done_cyc); end
        checks++;
        if (r_steps !== 8) begin errors++; $display("FAIL clamp_steps got %0d want 8", r_steps); end
        checks++;
        if (r_sw_log !== 16'h1B1B) begin errors++; $display("FAIL clamp_sw_seq got %h want 1b1b", r_sw_log); end
        checks++;
        if (out_bits !== 8'h1E || final_state !== 3'd3) begin
            errors++;
            $display("FAIL clamp_result got out=%h final=%0d want 1e 3", out_bits, final_state);
        end
    endtask

    task automatic test_zero_steps();
        do_run(3'd3, 4'd0, 16'hFFFF, 1'b0);
        checks++;
        if (r_done_cyc !== 2) begin errors++; $display("FAIL zero_done_cycle got %0d want 2", r_done_cyc); end
        checks++;
        if (r_loads !== 1 || r_steps !== 0) begin
            errors++;
            $display("FAIL zero_pulses got loads=%0d steps=%0d want 1 0", r_loads, r_steps);
        end
        checks++;
        if (final_state !== 3'd3 || out_bits !== 8'h00) begin
            errors++;
            $display("FAIL zero_result got final=%0d out=%h want 3 00", final_state, out_bits);
        end
    endtask

    task automatic test_illegal();
        do_run(3'd6, 4'd4, 16'h0000, 1'b0);
        checks++;
        if (r_done_cyc !== 4) begin errors++; $display("FAIL illegal_done_cycle got %0d want 4", r_done_cyc); end
        checks++;
        if (r_err_at_done !== 1'b1 || r_steps !== 1) begin
            errors++;
            $display("FAIL illegal_err got err=%b steps=%0d want 1 1", r_err_at_done, r_steps);
        end
        checks++;
        if (final_state !== 3'd6) begin errors++; $display("FAIL illegal_final_state got %0d want 6", final_state); end
    endtask

    // Abort in the 2nd STEP (cycle 4); step 0 captured a 1 (0 -sw3-> 2).
    task automatic test_abort();
        int done_seen;
        done_seen = 0;
        @(negedge clk);
        start_state = 3'd0;
        num_steps   = 4'd3;
        sym_data    = 16'h0003;
        start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (fsm_step !== 1'b1) begin errors++; $display("FAIL abort_in_step got fsm_step=%b want 1", fsm_step); end
        abort = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || fsm_step !== 1'b0 || fsm_load !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got busy=%b step=%b load=%b done=%b want 0 0 0 0", busy, fsm_step, fsm_load, done);
        end
        abort = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", done_seen); end
        checks++;
        if (out_bits !== 8'h01 || err !== 1'b0 || final_state !== 3'd6) begin
            errors++;
            $display("FAIL abort_kept got out=%h err=%b final=%0d want 01 0 6", out_bits, err, final_state);
        end
        do_run(3'd0, 4'd3, 16'h0006, 1'b0);
        checks++;
        if (r_done_cyc !== 8 || out_bits !== 8'h06 || final_state !== 3'd2) begin
            errors++;
            $display("FAIL abort_rerun got cyc=%0d out=%h final=%0d want 8 06 2", r_done_cyc, out_bits, final_state);
        end
    endtask

    task automatic test_start_abort_idle();
        int loads;
        loads = 0;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (fsm_load || busy) loads++;
        end
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (loads !== 0) begin errors++; $display("FAIL start_abort_idle got %0d busy cycles want 0", loads); end
    endtask

    // start held high for the whole run, including the DONE cycle
    task automatic test_start_in_done();
        do_run(3'd0, 4'd3, 16'h0006, 1'b1);
        checks++;
        if (r_done_cyc !== 8 || r_loads !== 1) begin
            errors++;
            $display("FAIL start_held got cyc=%0d loads=%0d want 8 1", r_done_cyc, r_loads);
        end
        checks++;
        if (busy !== 1'b0 || fsm_load !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done got busy=%b load=%b want 0 0", busy, fsm_load);
        end
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int done_seen;
        done_seen = 0;
        @(negedge clk);
        start_state = 3'd0;
        num_steps   = 4'd3;
        sym_data    = 16'h0006;
        start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, err, out_bits, final_state, fsm_load, fsm_state_in, fsm_sw, fsm_step} !== 21'd0) begin
            errors++;
            $display("FAIL midreset_outputs got %h want 0",
                     {busy, done, err, out_bits, final_state, fsm_load, fsm_state_in, fsm_sw, fsm_step});
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        reset = 1'b0;
        checks++;
        if (done_seen !== 0) begin errors++; $display("FAIL midreset_no_done got %0d pulses want 0", done_seen); end
        do_run(3'd0, 4'd3, 16'h0006, 1'b0);
        checks++;
        if (r_done_cyc !== 8 || out_bits !== 8'h06 || final_state !== 3'd2 || r_err_at_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_rerun got cyc=%0d out=%h final=%0d err=%b want 8 06 2 0",
                     r_done_cyc, out_bits, final_state, r_err_at_done);
        end
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        start_state = 3'd0;
        num_steps   = 4'd0;
        sym_data    = 16'h0000;
        @(negedge clk);
        test_reset();
        test_basic();
        test_clamp();
        test_zero_steps();
        test_illegal();
        test_abort();
        test_start_abort_idle();
        test_start_in_done();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/moore_seq_ctrl.md
MOORE_SEQ_CTRL -- requirements
Module: moore_seq_ctrl

Interface
REQ-001 SHALL have: clk  in  1  clock; all logic on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: start  in  1  run request, sampled only in IDLE.
REQ-004 SHALL have: abort  in  1  cancel the run in progress.
REQ-005 SHALL have: start_state  in  3  FSM state to load at run start.
REQ-006 SHALL have: num_steps  in  4  steps to execute; values 9..15 clamp to 8.
REQ-007 SHALL have: sym_data  in  16  eight 2-bit input symbols; symbol i at bits [2i+1:2i].
REQ-008 SHALL have: busy  out  1  high whenever state is not IDLE.
REQ-009 SHALL have: done  out  1  one-cycle completion pulse.
REQ-010 SHALL have: err  out  1  run ended on an illegal FSM state; valid with done.
REQ-011 SHALL have: out_bits  out  8  captured FSM output of step i at bit i.
REQ-012 SHALL have: final_state  out  3  FSM state at completion.
REQ-013 SHALL have: fsm_load  out  1  drives the 5-state Moore FSM reset (loads state_in).
REQ-014 SHALL have: fsm_state_in  out  3  start state presented to the FSM.
REQ-015 SHALL have: fsm_sw  out  2  input symbol to the FSM.
REQ-016 SHALL have: fsm_step  out  1  drives the FSM ctrl_in (advance enable).
REQ-017 SHALL have: fsm_state  in  3  current FSM state.
REQ-018 SHALL have: fsm_out  in  1  registered FSM output.

Function
REQ-019 SHALL implement states IDLE, LOAD, STEP, SAMPLE, DONE; all outputs registered.
REQ-020 IDLE with start=1 SHALL latch start_state, clamped num_steps and sym_data, clear out_bits, err and the step index, and go to LOAD.
REQ-021 LOAD SHALL assert fsm_load for exactly one cycle with fsm_state_in = latched start_state, then go to STEP, or to DONE if num_steps = 0.
REQ-022 STEP SHALL assert fsm_step for exactly one cycle with fsm_sw = symbol[index], then go to SAMPLE.
REQ-023 SAMPLE SHALL write fsm_out into out_bits[index] and increment the index.
REQ-024 After SAMPLE, if the index equals num_steps the block SHALL go to DONE; otherwise it SHALL go back to STEP.
REQ-025 If fsm_state > 4 in SAMPLE, the block SHALL set err, skip remaining steps and go to DONE.
REQ-026 DONE SHALL pulse done for one cycle, load final_state from fsm_state, and return to IDLE.
REQ-027 Timing: with start sampled at edge E0, done SHALL be high in cycle 2N+2 after E0; for N = 0 it SHALL be high in cycle 2.
REQ-028 start while busy SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-029 abort while busy SHALL return to IDLE at the next edge, drop fsm_step and fsm_load, produce no done, and leave out_bits, final_state and err unchanged.
REQ-030 abort and start asserted together in IDLE: abort SHALL win and no run SHALL start.
REQ-031 fsm_sw SHALL hold its last value outside STEP; fsm_step and fsm_load SHALL never be high together.

Reset
REQ-032 reset SHALL force IDLE, clear the index, and clear busy, done, err, out_bits, final_state, fsm_load, fsm_state_in, fsm_sw and fsm_step to 0.
REQ-033 reset mid-run SHALL abandon the run with no done pulse; the first start after reset deassertion SHALL be accepted.

Structure
REQ-034 Package moore_seq_pkg SHALL hold the controller state enum, MAX_STEPS=8, NUM_FSM_STATES=5 and SYM_W=2.
REQ-035 The block SHALL be a single module with no sub-modules; the Moore FSM is instantiated beside it in the testbench or top level.

Verification
REQ-036 start_state=0, sym_data=0x0006, num_steps=3 -> FSM path 0->3->2->2; out_bits=0x06, final_state=2, err=0; done in cycle 8.
REQ-037 num_steps=0, start_state=3 -> fsm_load pulse and no fsm_step; done in cycle 2, final_state=3, out_bits=0.
REQ-038 num_steps=12 -> exactly 8 fsm_step pulses; done in cycle 18.
REQ-039 start_state=6 -> err=1 after the first SAMPLE, done in cycle 4, final_state=6.
REQ-040 abort during the 2nd STEP -> IDLE next cycle, no done, busy=0; a following start with new inputs completes normally.
REQ-041 reset asserted mid-run, then start repeated -> all outputs 0 during reset; the second run yields the same results as REQ-036.
